// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the adder arbiter.
// State encodings, op codes and default datapath width.
package adder_arb_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int DEF_WIDTH = 16;

endpackage

// File: rtl/adder_arbiter_rr_select.sv
// Combinational round-robin picker: first set request
// at or after ptr, wrapping N-1 -> 0.
module rr_select #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           any_valid,
  output logic [IDW-1:0] winner
);

  logic [IDW:0] idx;
  logic         found;

  always_comb begin
    any_valid = |req;
    winner    = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(N)) idx = idx - (IDW+1)'(N);
      if (!found && req[idx[IDW-1:0]]) begin
        found  = 1'b1;
        winner = idx[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin sequencer sharing one combinational
// add/sub unit among NUM_REQ requesters.
import adder_arb_defs::*;

module adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_sel,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_carry,
  output logic                     rsp_overflow,
  output logic [IDW-1:0]           grant_id,
  output logic                     busy,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  output logic                     add_sel,
  input  logic [WIDTH-1:0]         add_sum,
  input  logic                     add_carry,
  input  logic                     add_overflow
);

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] winner;
  logic           any_valid;
  logic           own_ready;
  logic           accept;
  logic           done;

  rr_select #(
    .N   (NUM_REQ),
    .IDW (IDW)
  ) u_rr_select (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .any_valid (any_valid),
    .winner    (winner)
  );

  assign own_ready = rsp_ready[grant_id];
  assign accept    = (state == ST_IDLE) && any_valid;
  assign done      = (state == ST_RESP) && own_ready;
  assign busy      = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    unique case (state)
      ST_IDLE: begin
        if (any_valid) begin
          req_ready = NUM_REQ'(1) << winner;
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: begin
        rsp_valid = NUM_REQ'(1) << grant_id;
        if (own_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr       <= '0;
      grant_id     <= '0;
      add_a        <= '0;
      add_b        <= '0;
      add_sel      <= 1'b0;
      rsp_sum      <= '0;
      rsp_carry    <= 1'b0;
      rsp_overflow <= 1'b0;
    end else begin
      if (accept) begin
        grant_id <= winner;
        add_a    <= req_a[winner*WIDTH +: WIDTH];
        add_b    <= req_b[winner*WIDTH +: WIDTH];
        add_sel  <= req_sel[winner];
      end
      if (state == ST_EXEC) begin
        rsp_sum      <= add_sum;
        rsp_carry    <= add_carry;
        rsp_overflow <= add_overflow;
      end
      // Pointer advances only on a completed response.
      if (done) begin
        rr_ptr <= (grant_id == IDW'(NUM_REQ-1)) ? '0
                : grant_id + IDW'(1);
      end
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with a
// behavioural 16-bit add/sub unit beside it.
module tb_adder_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_sel;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready;
  logic [W-1:0]   rsp_sum;
  logic           rsp_carry;
  logic           rsp_overflow;
  logic [1:0]     grant_id;
  logic           busy;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic           add_sel;
  logic [W-1:0]   add_sum;
  logic           add_carry;
  logic           add_overflow;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  adder_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_sel      (req_sel),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_sum      (rsp_sum),
    .rsp_carry    (rsp_carry),
    .rsp_overflow (rsp_overflow),
    .grant_id     (grant_id),
    .busy         (busy),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_sel      (add_sel),
    .add_sum      (add_sum),
    .add_carry    (add_carry),
    .add_overflow (add_overflow)
  );

  logic [W:0] t;
  always_comb begin
    if (add_sel) t = {1'b0, add_a} - {1'b0, add_b};
    else         t = {1'b0, add_a} + {1'b0, add_b};
    add_sum   = t[W-1:0];
    add_carry = t[W];
    if (add_sel)
      add_overflow = (add_a[W-1] != add_b[W-1]) && (t[W-1] != add_a[W-1]);
    else
      add_overflow = (add_a[W-1] == add_b[W-1]) && (t[W-1] != add_a[W-1]);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic sel);
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    req_sel[id]      = sel;
  endtask

  // One isolated operation from requester id, fully checked.
  task automatic op(input int id, input logic [W-1:0] a,
                    input logic [W-1:0] b, input logic sel,
                    input logic [W-1:0] es, input logic ec,
                    input logic ev);
    @(negedge clk);
    set_req(id, a, b, sel);
    req_valid     = '0;
    req_valid[id] = 1'b1;
    #1;
    chk("accept", 32'(req_ready), 32'(1 << id));
    @(negedge clk);
    req_valid = '0;
    chk("exec_busy", 32'(busy), 1);
    chk("exec_gid", 32'(grant_id), 32'(id));
    chk("exec_rspv", 32'(rsp_valid), 0);
    chk("exec_opa", 32'(add_a), 32'(a));
    @(negedge clk);
    chk("rsp_valid", 32'(rsp_valid), 32'(1 << id));
    chk("rsp_sum", 32'(rsp_sum), 32'(es));
    chk("rsp_carry", 32'(rsp_carry), 32'(ec));
    chk("rsp_ovf", 32'(rsp_overflow), 32'(ev));
    rsp_ready[id] = 1'b1;
    @(negedge clk);
    rsp_ready = '0;
    chk("idle_busy", 32'(busy), 0);
    chk("idle_rspv", 32'(rsp_valid), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int          order [5]  = '{0, 1, 2, 3, 0};
  logic [15:0] csum  [4]  = '{16'h0101, 16'h0202, 16'h0303, 16'h0404};

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    req_a     = '0;
    req_b     = '0;
    req_sel   = '0;
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rdy", 32'(req_ready), 0);
    chk("rst_rspv", 32'(rsp_valid), 0);
    chk("rst_gid", 32'(grant_id), 0);
    chk("rst_sum", 32'(rsp_sum), 0);
    chk("rst_adda", 32'(add_a), 0);
    chk("rst_sel", 32'(add_sel), 0);
    @(negedge clk);
    rst_n = 1'b1;

    op(0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    op(2, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b1, 1'b0);
    op(3, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);

    // rr_ptr wrapped to 0: requester 0 beats 3.
    @(negedge clk);
    req_valid = 4'b1001;
    #1;
    chk("wrap_ptr", 32'(req_ready), 32'b0001);
    req_valid = '0;

    // Contention from reset, all valid, all consuming.
    do_reset();
    for (int i = 0; i < N; i++)
      set_req(i, 16'(16'h0100 * (i + 1)), 16'(i + 1), 1'b0);
    req_valid = 4'b1111;
    rsp_ready = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("cont_grant", 32'(req_ready), 32'(1 << order[k]));
      @(negedge clk);
      chk("cont_exec_rdy", 32'(req_ready), 0);
      @(negedge clk);
      chk("cont_rspv", 32'(rsp_valid), 32'(1 << order[k]));
      chk("cont_sum", 32'(rsp_sum), 32'(csum[order[k]]));
      @(negedge clk);
      #1;
    end

    // Backpressure on requester 1 while others stay valid.
    rsp_ready = 4'b1101;
    chk("bp_grant", 32'(req_ready), 32'b0010);
    @(negedge clk);
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      chk("bp_rspv", 32'(rsp_valid), 32'b0010);
      chk("bp_sum", 32'(rsp_sum), 32'h0202);
      chk("bp_busy", 32'(busy), 1);
      chk("bp_rdy", 32'(req_ready), 0);
      @(negedge clk);
    end
    rsp_ready = 4'b1111;
    @(negedge clk);
    #1;
    chk("bp_next", 32'(req_ready), 32'b0100);
    req_valid = '0;
    rsp_ready = '0;

    // Reset during EXEC discards the operation.
    @(negedge clk);
    set_req(1, 16'h1234, 16'h1111, 1'b0);
    req_valid = 4'b0010;
    #1;
    chk("rx_accept", 32'(req_ready), 32'b0010);
    @(negedge clk);
    req_valid = '0;
    rsp_ready = 4'b1111;
    rst_n     = 1'b0;
    #1;
    chk("rx_rspv", 32'(rsp_valid), 0);
    chk("rx_busy", 32'(busy), 0);
    chk("rx_gid", 32'(grant_id), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rx_norsp", 32'(rsp_valid), 0);
    end
    rsp_ready = '0;
    req_valid = 4'b1010;
    #1;
    chk("rx_ptr0", 32'(req_ready), 32'b0010);
    req_valid = '0;
    @(negedge clk);
    chk("rx_idle", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Round-robin arbiter and sequencer that time-shares one 16-bit ripple-carry add/subtract unit among NUM_REQ requesters.
- Accepts one operation at a time through a valid/ready handshake and registers the operands. It drives the shared adder, registers sum/carry/overflow and returns them to the originating requester through a response handshake.
- Sits between the ALU front-end ports and the single adder instance; the adder stays purely combinational.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 16, operand/result width; must match the adder
- IDW, $clog2(NUM_REQ), width of the requester index

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NUM_REQ  per-requester operation request
- req_ready  output  NUM_REQ  one-hot accept strobe
- req_a  input  NUM_REQ*WIDTH  packed augend/minuend; requester i at [i*WIDTH +: WIDTH]
- req_b  input  NUM_REQ*WIDTH  packed addend/subtrahend
- req_sel  input  NUM_REQ  per-requester op: 0=add, 1=subtract
- rsp_valid  output  NUM_REQ  one-hot result-valid to the owning requester
- rsp_ready  input  NUM_REQ  per-requester result accept
- rsp_sum  output  WIDTH  shared result bus
- rsp_carry  output  1  carry (add) / borrow (subtract) from the adder
- rsp_overflow  output  1  signed overflow from the adder
- grant_id  output  IDW  index of the current owner
- busy  output  1  high in any state other than IDLE
- add_a  output  WIDTH  operand A to the adder
- add_b  output  WIDTH  operand B to the adder
- add_sel  output  1  op select to the adder
- add_sum  input  WIDTH  adder sum
- add_carry  input  1  adder carry/borrow
- add_overflow  input  1  adder overflow

Behaviour:
- Reset (async, rst_n low) clears:
  - state=IDLE, rr_ptr=0, grant_id=0
  - operand regs=0, add_sel=0
  - result regs=0
  - req_ready=0, rsp_valid=0, busy=0
- States: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - If any req_valid is high, pick the first requester at or after rr_ptr, wrapping NUM_REQ-1 -> 0.
  - req_ready[g] is combinationally high for the winner in that cycle only; req_ready is 0 in all other states.
  - On that edge, capture req_a/req_b/req_sel of g into add_a/add_b/add_sel, set grant_id=g, and go to EXEC.
  - If no request is valid, stay in IDLE.
- EXEC: add_* stay stable. On the edge, register add_sum/add_carry/add_overflow into the result regs and go to RESP.
- RESP:
  - rsp_valid[grant_id]=1; rsp_sum/carry/overflow are held stable.
  - When rsp_ready[grant_id]=1, on that edge set rsp_valid=0, rr_ptr=(grant_id+1) mod NUM_REQ, and go to IDLE.
- Latency: accept in cycle 0, rsp_valid high in cycle 2. Minimum issue interval is 3 cycles per operation.
- The results are the adder's outputs unmodified; the arbiter does no arithmetic.
- Fairness: a requester that holds req_valid is granted within NUM_REQ operations.
- Boundary conditions:
  - Requester drops req_valid before being granted: legal, nothing is accepted.
  - req_valid and rsp_ready both high in the same cycle for different requesters: independent; only grant_id's rsp_ready matters.
  - rsp_ready held low: the block stalls in RESP indefinitely and other requesters wait. No timeout.
  - rr_ptr wraps mod NUM_REQ; for non-power-of-2 NUM_REQ, values >= NUM_REQ are never reached.
  - rsp_ready from a non-owner: ignored.
  - Reset mid-operation: the in-flight transaction is discarded with no response; behaviour is as after reset.
  - Outputs rsp_sum/carry/overflow hold their last value outside RESP, so consumers qualify them with rsp_valid.

Decomposition:
- Shared header/package adder_arb_defs:
  - state encodings ST_IDLE=2'd0, ST_EXEC=2'd1, ST_RESP=2'd2
  - OP_ADD=1'b0, OP_SUB=1'b1
  - default WIDTH=16
- One sub-module, rr_select:
  - combinational round-robin picker
  - inputs: req vector, rr_ptr
  - outputs: any_valid, winner index
  - reusable by later arbiters
- The FSM, operand/result registers and handshakes live in adder_arbiter. The adder is instantiated beside it at the next level up.

Test Plan:
- Single add: requester 0 issues 0x7FFF + 0x0001 (sel=0). Required: req_ready[0] in the same cycle; rsp_valid[0] 2 cycles later with sum=0x8000, carry=0, overflow=1.
- Subtract: requester 2 issues 0x0005 - 0x0007 (sel=1). Required: sum=0xFFFE, carry(borrow)=1, overflow=0, grant_id=2.
- Contention: all 4 requesters are valid continuously starting from reset. Required: grant order 0,1,2,3,0, and each response reaches only its owner.
- Backpressure: requester 1 holds rsp_ready=0 for 10 cycles. Required: rsp_valid[1] and the data are stable; busy=1; req_ready stays 0 for the other requesters until the handshake.
- Wrap carry: 0xFFFF + 0x0001 from requester 3. Required: sum=0x0000, carry=1, overflow=0; next rr_ptr=0.
- Reset in EXEC: assert rst_n low mid-operation. Required: immediately rsp_valid=0, busy=0, state IDLE; no response after release; the next request is granted from rr_ptr=0.
